// File: rtl/pipelined_csel_adder_if.sv
// Valid/ready stream bundle for the pipelined carry-select adder:
// an operand beat enters on the in_* side and a result beat leaves on the out_* side.
interface pipelined_csel_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: one BLOCK-bit slice is resolved per stage,
// with already-resolved low blocks riding along so the full result leaves together.
module pipelined_csel_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipelined_csel_adder_if.slave   bus
);
  localparam int STAGES = WIDTH / BLOCK;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_first;

  logic             vld [STAGES];
  logic             cry [STAGES];
  logic [WIDTH-1:0] res [STAGES];
  logic [WIDTH-1:0] opa [STAGES];
  logic [WIDTH-1:0] opb [STAGES];
  logic             ovf_q;

  logic [WIDTH-1:0] nres [STAGES];
  logic             ncry [STAGES];
  logic             novf;

  // One global enable: the whole pipeline shifts or holds as a unit.
  assign adv     = ~vld[STAGES-1] | bus.out_ready;
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign c_first = bus.sub ? 1'b1 : bus.cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [BLOCK-1:0] ba;
    logic [BLOCK-1:0] bb;
    logic [WIDTH-1:0] rin;
    logic             cin_k;
    logic [BLOCK:0]   s0;
    logic [BLOCK:0]   s1;
    logic [BLOCK-1:0] sel_s;
    logic             sel_c;
    logic [WIDTH-1:0] r_new;

    if (k == 0) begin : g_head
      assign ba    = bus.a[BLOCK-1:0];
      assign bb    = b_eff[BLOCK-1:0];
      assign rin   = '0;
      assign cin_k = c_first;
    end else begin : g_body
      assign ba    = opa[k-1][k*BLOCK +: BLOCK];
      assign bb    = opb[k-1][k*BLOCK +: BLOCK];
      assign rin   = res[k-1];
      assign cin_k = cry[k-1];
    end

    // Both carry-in hypotheses are formed up front; the incoming carry only steers a mux.
    assign s0    = {1'b0, ba} + {1'b0, bb};
    assign s1    = {1'b0, ba} + {1'b0, bb} + {{BLOCK{1'b0}}, 1'b1};
    assign sel_s = cin_k ? s1[BLOCK-1:0] : s0[BLOCK-1:0];
    assign sel_c = cin_k ? s1[BLOCK] : s0[BLOCK];

    always_comb begin
      r_new                      = rin;
      r_new[k*BLOCK +: BLOCK]    = sel_s;
    end

    assign nres[k] = r_new;
    assign ncry[k] = sel_c;

    if (k == STAGES - 1) begin : g_tail
      assign novf = (sel_s[BLOCK-1] ^ ba[BLOCK-1] ^ bb[BLOCK-1]) ^ sel_c;
    end
  end

  // Stage registers; operands for not-yet-resolved blocks travel alongside the partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld[k] <= 1'b0;
        cry[k] <= 1'b0;
        res[k] <= '0;
        opa[k] <= '0;
        opb[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      vld[0] <= bus.in_valid;
      opa[0] <= bus.a;
      opb[0] <= b_eff;
      for (int k = 1; k < STAGES; k++) begin
        vld[k] <= vld[k-1];
        opa[k] <= opa[k-1];
        opb[k] <= opb[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        res[k] <= nres[k];
        cry[k] <= ncry[k];
      end
      ovf_q <= novf;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld[STAGES-1];
  assign bus.sum       = res[STAGES-1];
  assign bus.cout      = cry[STAGES-1];
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Directed and random checks of the pipelined carry-select adder, plus a
// parameter sweep over single-stage, deep and 64-bit configurations.
module tb_pipelined_csel_adder;
  localparam int WIDTH  = 32;
  localparam int BLOCK  = 8;
  localparam int STAGES = WIDTH / BLOCK;
  localparam int NSWEEP = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipelined_csel_adder_if #(.WIDTH(32)) bus ();
  pipelined_csel_adder_if #(.WIDTH(32)) bus1 ();
  pipelined_csel_adder_if #(.WIDTH(32)) bus8 ();
  pipelined_csel_adder_if #(.WIDTH(64)) bus64 ();

  pipelined_csel_adder #(.WIDTH(32), .BLOCK(8))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipelined_csel_adder #(.WIDTH(32), .BLOCK(32)) dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pipelined_csel_adder #(.WIDTH(32), .BLOCK(4))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  pipelined_csel_adder #(.WIDTH(64), .BLOCK(16)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Independent reference: overflow from operand/result sign bits rather than carries.
  function automatic logic [33:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic cin, input logic sub);
    logic [31:0] be;
    logic [32:0] t;
    logic        v;
    be = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + {32'd0, (sub ? 1'b1 : cin)};
    v  = (a[31] == be[31]) && (t[31] != a[31]);
    return {v, t[32], t[31:0]};
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic sub);
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
    #1;
    checkOutput("in_ready_idle", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic collectResult(input string tag, input logic [31:0] exp_sum,
                               input logic exp_cout, input logic exp_ovf);
    int n;
    #1;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_latency"}, n, STAGES);
    checkOutput({tag, "_sum"}, bus.sum, exp_sum);
    checkOutput({tag, "_cout"}, bus.cout, exp_cout);
    checkOutput({tag, "_ovf"}, bus.ovf, exp_ovf);
    @(negedge clk);
    #1;
    checkOutput({tag, "_nodup"}, bus.out_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [33:0]  sq[$];
    logic [33:0]  got;
    logic [33:0]  held;
    logic         prev_stall;
    logic         have_beat;
    int           sent;
    int           recv;
    int           cyc;
    logic [64:0]  q1[$];
    logic [64:0]  q8[$];
    logic [64:0]  q64[$];
    logic [31:0]  sa;
    logic [31:0]  sb;
    logic [63:0]  la;
    logic [63:0]  lb;
    logic         sc;
    bit           seen1;
    bit           seen8;
    bit           seen64;

    bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.cin = 0; bus.sub = 0; bus.out_ready = 0;
    bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.cin = 0; bus1.sub = 0; bus1.out_ready = 1;
    bus8.in_valid = 0; bus8.a = 0; bus8.b = 0; bus8.cin = 0; bus8.sub = 0; bus8.out_ready = 1;
    bus64.in_valid = 0; bus64.a = 0; bus64.b = 0; bus64.cin = 0; bus64.sub = 0; bus64.out_ready = 1;

    #1;
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_in_ready", bus.in_ready, 1);
    checkOutput("reset_sum", bus.sum, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    $display("[TB] directed vectors");
    applyStimulus(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    collectResult("ripple_all", 32'h0000_0000, 1'b1, 1'b0);
    applyStimulus(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    collectResult("pos_ovf", 32'h8000_0000, 1'b0, 1'b1);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    collectResult("neg_ovf", 32'h0000_0000, 1'b1, 1'b1);
    applyStimulus(32'd5, 32'd7, 1'b1, 1'b1);
    collectResult("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    collectResult("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);
    applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    collectResult("block_carry", 32'h0000_0100, 1'b0, 1'b0);

    $display("[TB] random stream with backpressure");
    sent = 0; recv = 0; cyc = 0; prev_stall = 0; have_beat = 0; held = '0;
    while (recv < 64 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!have_beat && sent < 64 && $urandom_range(0, 9) < 7) begin
        bus.a   = $urandom;
        bus.b   = $urandom;
        bus.cin = 1'($urandom_range(0, 1));
        bus.sub = 1'($urandom_range(0, 1));
        have_beat = 1;
      end
      bus.in_valid  = have_beat;
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        checkOutput("stall_valid", bus.out_valid, 1);
        checkOutput("stall_stable", {bus.ovf, bus.cout, bus.sum}, held);
      end
      if (bus.in_valid && bus.in_ready) begin
        sq.push_back(refModel(bus.a, bus.b, bus.cin, bus.sub));
        sent++;
        have_beat = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        got = {bus.ovf, bus.cout, bus.sum};
        if (sq.size() == 0) checkOutput("stream_extra", 1, 0);
        else checkOutput("stream_result", got, sq.pop_front());
        recv++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      held       = {bus.ovf, bus.cout, bus.sum};
    end
    checkOutput("stream_count", recv, 64);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("stream_drained", bus.out_valid, 0);

    $display("[TB] reset with beats in flight");
    @(negedge clk);
    bus.sub = 0; bus.cin = 0;
    bus.a = 32'h10; bus.b = 32'h20; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.a = 32'h100; bus.b = 32'h200;
    @(negedge clk);
    bus.a = 32'h3; bus.b = 32'h4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    checkOutput("pre_reset_valid", bus.out_valid, 1);
    checkOutput("pre_reset_sum", bus.sum, 32'h30);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", bus.out_valid, 0);
    checkOutput("async_reset_sum", bus.sum, 0);
    checkOutput("async_reset_cout", bus.cout, 0);
    checkOutput("async_reset_ovf", bus.ovf, 0);
    checkOutput("async_reset_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    applyStimulus(32'd1, 32'd2, 1'b0, 1'b0);
    collectResult("post_reset", 32'd3, 1'b0, 1'b0);

    $display("[TB] parameter sweep");
    seen1 = 0; seen8 = 0; seen64 = 0;
    for (int i = 0; i < NSWEEP + 12; i++) begin
      @(negedge clk);
      if (i < NSWEEP) begin
        if (i == 0) begin
          sa = 32'hFFFF_FFFF; sb = 32'h0; la = 64'hFFFF_FFFF_FFFF_FFFF; lb = 64'h0; sc = 1'b1;
        end else if (i == 1) begin
          sa = 32'hFFFF_FFFF; sb = 32'h1; la = 64'hFFFF_FFFF_FFFF_FFFF; lb = 64'h1; sc = 1'b0;
        end else begin
          sa = $urandom; sb = $urandom; la = {$urandom, $urandom}; lb = {$urandom, $urandom};
          sc = 1'($urandom_range(0, 1));
        end
        bus1.a = sa; bus1.b = sb; bus1.cin = sc; bus1.in_valid = 1'b1;
        bus8.a = sa; bus8.b = sb; bus8.cin = sc; bus8.in_valid = 1'b1;
        bus64.a = la; bus64.b = lb; bus64.cin = sc; bus64.in_valid = 1'b1;
      end else begin
        bus1.in_valid = 1'b0; bus8.in_valid = 1'b0; bus64.in_valid = 1'b0;
      end
      #1;
      if (bus1.in_valid && bus1.in_ready)
        q1.push_back({32'd0, {1'b0, bus1.a} + {1'b0, bus1.b} + {32'd0, bus1.cin}});
      if (bus8.in_valid && bus8.in_ready)
        q8.push_back({32'd0, {1'b0, bus8.a} + {1'b0, bus8.b} + {32'd0, bus8.cin}});
      if (bus64.in_valid && bus64.in_ready)
        q64.push_back({1'b0, bus64.a} + {1'b0, bus64.b} + {64'd0, bus64.cin});
      if (bus1.out_valid) begin
        if (!seen1) begin checkOutput("s1_latency", i, 1); seen1 = 1; end
        if (q1.size() == 0) checkOutput("s1_extra", 1, 0);
        else checkOutput("s1_result", {32'd0, bus1.cout, bus1.sum}, q1.pop_front());
      end
      if (bus8.out_valid) begin
        if (!seen8) begin checkOutput("s8_latency", i, 8); seen8 = 1; end
        if (q8.size() == 0) checkOutput("s8_extra", 1, 0);
        else checkOutput("s8_result", {32'd0, bus8.cout, bus8.sum}, q8.pop_front());
      end
      if (bus64.out_valid) begin
        if (!seen64) begin checkOutput("w64_latency", i, 4); seen64 = 1; end
        if (q64.size() == 0) checkOutput("w64_extra", 1, 0);
        else checkOutput("w64_result", {bus64.cout, bus64.sum}, q64.pop_front());
      end
    end
    checkOutput("s1_drain", q1.size(), 0);
    checkOutput("s8_drain", q8.size(), 0);
    checkOutput("w64_drain", q64.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_csel_adder.md
# pipelined_csel_adder

Parametrised, pipelined carry-select adder/subtractor with a valid/ready stream interface. The WIDTH-bit operation is split into WIDTH/BLOCK blocks. Each pipeline stage resolves one block: it precomputes the block sum for carry-in 0 and carry-in 1, then selects using the registered carry from the previous stage. The block sits in the datapath arithmetic library and replaces single-cycle carry-select adders where WIDTH is large enough to limit timing, or where add/subtract mode and overflow detection are needed.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of BLOCK.
- BLOCK, 8, bits resolved per pipeline stage; STAGES = WIDTH/BLOCK (derived, not overridable).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of bit WIDTH-1; for sub, 1 = no borrow.
- ovf  out  1  signed overflow (carry into MSB XOR carry out of MSB).

## Operation
- Input transform at acceptance: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (k = 0..STAGES-1) holds a valid bit, a carry register, the result blocks 0..k-1 already resolved, and operand blocks k..STAGES-1 still pending.
- Stage k computes block k twice:
  - s0/c0_out with carry-in 0.
  - s1/c1_out with carry-in 1.
  - It then selects by the incoming carry (c0 for stage 0, otherwise the carry register of stage k-1).
- The final stage also computes ovf from the carry into bit WIDTH-1 and the selected carry out.
- Result blocks are skew-aligned: lower blocks ride along the pipeline so the complete sum, cout and ovf appear together.
- Pipeline advance: adv = ~out_valid | out_ready. This is a single global enable; all stages shift together or hold together.
- in_ready = adv (combinational). A beat is accepted when in_valid & in_ready.
- On adv, each stage's valid bit loads from the previous stage (stage 0 loads in_valid). Bubbles propagate as valid=0.
- When adv=0, every register holds. sum, cout and ovf stay stable while out_valid=1 and out_ready=0.
- Ordering: results emerge strictly in acceptance order. No drop, no duplication.
- STAGES=1 degenerates to a registered single-block carry-select adder, latency 1.

## Timing
- Latency: a beat accepted at edge t produces out_valid=1 with its result after edge t+STAGES-1 (visible in cycle t+STAGES), with no stalls. Each stall cycle adds one.
- Throughput: one beat per cycle while out_ready=1.
- Reset (rst_n=0, asynchronous): all valid bits, carry registers, sum, cout and ovf clear to 0.
  - out_valid=0 immediately.
  - in_ready=1 (follows from out_valid=0).
  - Beats in flight are discarded.
- Reset deassertion: the first acceptance can occur on the first rising edge with rst_n=1.
- Simultaneous output handshake and input acceptance in the same cycle are legal. Full throughput is required with no bubble insertion.
- in_valid with in_ready=0: the beat is not taken. The source must hold it; the block does not sample it.
- Carry registers are meaningful only when the matching valid bit is 1. Their contents under valid=0 are don't-care but must not be X after reset.

## Test plan
- WIDTH=32, BLOCK=8: a=0xFFFFFFFF, b=0, cin=1, sub=0 -> sum=0x00000000, cout=1, ovf=0. Carry ripples through all 4 blocks; out_valid rises exactly 4 cycles after acceptance.
- Signed overflow:
  - a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0, ovf=1.
  - a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
- Subtract:
  - a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0.
  - a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Stream of 64 random beats, in_valid random at 70%, out_ready random at 50% -> every result matches the reference model in order. Outputs are bit-stable during every stall. No beat is lost or duplicated.
- Assert rst_n=0 with 3 beats in flight -> out_valid=0 and sum/cout/ovf=0 in the same cycle. After release, one new beat a=1, b=2 yields sum=3 exactly 4 cycles later, with no stale results emitted.
- Parameter sweep: BLOCK=32 (STAGES=1, latency 1), BLOCK=4 (STAGES=8, latency 8), and WIDTH=64/BLOCK=16 -> a+b+cin correct for 1000 random vectors each, including 0xFF…F + 1 carry propagation.
